// File: rtl/cpx2real.sv
// Complex-to-real quadrature upconverter: fs/4 LO mixing (1,0,-1,0), serial shift-add gain,
// round-half-up and saturation to a 12-bit real output, one sample per CADENCE clocks.
module cpx2real #(
  parameter int CADENCE = 20,
  parameter int IN_W    = 13,
  parameter int OUT_W   = 12,
  parameter int GAIN_W  = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     EN,
  input  logic signed [IN_W-1:0]   Re,
  input  logic signed [IN_W-1:0]   Im,
  input  logic        [GAIN_W-1:0] gain,
  output logic signed [OUT_W-1:0]  OUT,
  output logic                     valid,
  output logic                     sat
);

  localparam int CNT_W  = $clog2(CADENCE);
  localparam int BIT_W  = $clog2(GAIN_W + 1);
  localparam int X_W    = IN_W + 1;
  localparam int ACC_W  = IN_W + GAIN_W + 1;
  localparam int ACCR_W = ACC_W + 1;

  localparam logic signed [ACCR_W-1:0] RND_HALF = ACCR_W'(2 ** (GAIN_W - 2));
  localparam logic signed [ACCR_W-1:0] OUT_MAX  = ACCR_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACCR_W-1:0] OUT_MIN  = -ACCR_W'(2 ** (OUT_W - 1));

  // A new tick must never arrive while the multiplier is still busy.
  if (GAIN_W + 2 >= CADENCE) begin : g_bad_cadence
    $error("cpx2real: CADENCE must exceed GAIN_W+2");
  end

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ROUND, S_EMIT} state_t;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [1:0]                r_phase;
  logic [GAIN_W-1:0]         r_gain;
  logic [BIT_W-1:0]          r_bit;
  logic signed [ACC_W-1:0]   r_x;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [OUT_W-1:0]   r_res;
  logic                      r_res_sat;
  logic signed [OUT_W-1:0]   r_out;
  logic                      r_valid;
  logic                      r_sat;

  logic                      w_tick;
  logic signed [X_W-1:0]     w_re_ext;
  logic signed [X_W-1:0]     w_im_ext;
  logic signed [X_W-1:0]     w_x;
  logic signed [ACCR_W-1:0]  w_acc_rnd;
  logic signed [ACCR_W-1:0]  w_r;
  logic signed [OUT_W-1:0]   w_clip;
  logic                      w_clip_sat;

  assign w_tick   = EN && (r_cnt == '0);
  assign w_re_ext = {Re[IN_W-1], Re};
  assign w_im_ext = {Im[IN_W-1], Im};

  // Negation happens one bit wider than the input so -(-2^(IN_W-1)) stays positive.
  always_comb begin
    w_x = w_re_ext;
    case (r_phase)
      2'd0: w_x = w_re_ext;
      2'd1: w_x = -w_im_ext;
      2'd2: w_x = -w_re_ext;
      2'd3: w_x = w_im_ext;
      default: w_x = w_re_ext;
    endcase
  end

  assign w_acc_rnd = {r_acc[ACC_W-1], r_acc} + RND_HALF;
  assign w_r       = w_acc_rnd >>> (GAIN_W - 1);

  always_comb begin
    w_clip     = w_r[OUT_W-1:0];
    w_clip_sat = 1'b0;
    if (w_r > OUT_MAX) begin
      w_clip     = OUT_MAX[OUT_W-1:0];
      w_clip_sat = 1'b1;
    end else if (w_r < OUT_MIN) begin
      w_clip     = OUT_MIN[OUT_W-1:0];
      w_clip_sat = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= CNT_W'(CADENCE - 1);
      r_phase   <= 2'd0;
      r_gain    <= '0;
      r_bit     <= '0;
      r_x       <= '0;
      r_acc     <= '0;
      r_res     <= '0;
      r_res_sat <= 1'b0;
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_sat   <= 1'b0;

      if (EN) begin
        if (r_cnt == '0) begin
          r_cnt   <= CNT_W'(CADENCE - 1);
          r_phase <= r_phase + 2'd1;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_gain  <= gain;
            r_x     <= {{(ACC_W - X_W){w_x[X_W-1]}}, w_x};
            r_acc   <= '0;
            r_bit   <= '0;
            r_state <= S_MUL;
          end
        end
        // LSB-first shift-add: the multiplicand doubles as the gain shifts down.
        S_MUL: begin
          if (r_gain[0]) begin
            r_acc <= r_acc + r_x;
          end
          r_x    <= r_x <<< 1;
          r_gain <= r_gain >> 1;
          r_bit  <= r_bit + 1'b1;
          if (r_bit == BIT_W'(GAIN_W - 1)) begin
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_res     <= w_clip;
          r_res_sat <= w_clip_sat;
          r_state   <= S_EMIT;
        end
        S_EMIT: begin
          r_out   <= r_res;
          r_valid <= 1'b1;
          r_sat   <= r_res_sat;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign OUT   = r_out;
  assign valid = r_valid;
  assign sat   = r_sat;

endmodule

// File: tb/tb_cpx2real.sv
// Directed bench for cpx2real: LO phase sequence, rounding, saturation, EN freeze and reset abort.
module tb_cpx2real;

  logic               clock;
  logic               reset;
  logic               EN;
  logic signed [12:0] Re;
  logic signed [12:0] Im;
  logic        [9:0]  gain;
  logic signed [11:0] OUT;
  logic               valid;
  logic               sat;

  int total = 0;
  int bad   = 0;

  cpx2real dut (
    .clock (clock),
    .reset (reset),
    .EN    (EN),
    .Re    (Re),
    .Im    (Im),
    .gain  (gain),
    .OUT   (OUT),
    .valid (valid),
    .sat   (sat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns the number of rising edges until valid is seen, or -1 on timeout.
  task automatic wait_valid(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clock);
      #1;
      if (valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Checks one output sample, then one more edge for pulse width and hold.
  task automatic sample(input string tag, input int gap, input int exp_out,
                        input logic exp_sat);
    int n;
    wait_valid(60, n);
    $display("sample %s: edges=%0d out=%0d sat=%0d", tag, n, OUT, sat);
    check({tag, ".gap"}, n, gap);
    check({tag, ".out"}, OUT, exp_out);
    check({tag, ".sat"}, {31'd0, sat}, {31'd0, exp_sat});
    @(posedge clock);
    #1;
    check({tag, ".pulse"}, {31'd0, valid}, 0);
    check({tag, ".hold"}, OUT, exp_out);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    EN    = 1'b1;
    Re    = 13'sd100;
    Im    = 13'sd0;
    gain  = 10'd512;

    // Asynchronous reset: outputs clear before any clock edge.
    #2 reset = 1'b0;
    #1;
    check("rst.out", OUT, 0);
    check("rst.valid", {31'd0, valid}, 0);
    check("rst.sat", {31'd0, sat}, 0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;

    // Re=100, gain=1.0: phases 0..3,0 -> 100, 0, -100, 0, 100.
    sample("s0_p0", 32, 100, 1'b0);
    sample("s1_p1", 19, 0, 1'b0);
    sample("s2_p2", 19, -100, 1'b0);
    sample("s3_p3", 19, 0, 1'b0);
    sample("s4_p0", 19, 100, 1'b0);

    Re = 13'sd0; Im = 13'sd300;
    sample("s5_p1", 19, -300, 1'b0);
    sample("s6_p2", 19, 0, 1'b0);
    sample("s7_p3", 19, 300, 1'b0);
    sample("s8_p0", 19, 0, 1'b0);

    // Saturation with near-full-scale input and gain just under 2.0.
    Re = 13'sd4095; Im = 13'sd0; gain = 10'd1023;
    sample("s9_p1", 19, 0, 1'b0);
    sample("s10_p2", 19, -2048, 1'b1);
    sample("s11_p3", 19, 0, 1'b0);
    sample("s12_p0", 19, 2047, 1'b1);

    // Most negative input negated at phase 2 must clip, not wrap.
    Re = -13'sd4096; gain = 10'd512;
    sample("s13_p1", 19, 0, 1'b0);
    sample("s14_p2", 19, 2047, 1'b1);
    sample("s15_p3", 19, 0, 1'b0);

    // Rounding at gain 0.5: 1.5 -> 2, -1.5 -> -1, 0.5 -> 1.
    Re = 13'sd3; gain = 10'd256;
    sample("s16_p0", 19, 2, 1'b0);
    sample("s17_p1", 19, 0, 1'b0);
    sample("s18_p2", 19, -1, 1'b0);
    Re = 13'sd1;
    sample("s19_p3", 19, 0, 1'b0);
    sample("s20_p0", 19, 1, 1'b0);

    // EN low for 7 clocks mid-period delays the tick by 7; phase continues at 1.
    Re = 13'sd0; Im = -13'sd50; gain = 10'd512;
    EN = 1'b0;
    repeat (7) @(posedge clock);
    #1 EN = 1'b1;
    sample("s21_p1_endelay", 19, 50, 1'b0);

    // EN dropped right after a tick: that sample still completes.
    Re = 13'sd200;
    repeat (7) @(posedge clock);
    #1 EN = 1'b0;
    sample("s22_p2_enoff", 12, -200, 1'b0);
    wait_valid(30, n);
    $display("frozen window: edges=%0d", n);
    check("frozen.novalid", n, -1);

    // Reset during MUL aborts the sample; the next valid is the post-reset first one.
    Re = 13'sd100; Im = 13'sd77;
    EN = 1'b1;
    repeat (25) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("abort.out", OUT, 0);
    check("abort.valid", {31'd0, valid}, 0);
    check("abort.sat", {31'd0, sat}, 0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    sample("s23_p0_afterabort", 32, 100, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
